p19_uart_rx: RTL

UART receiver paired with the transmitter `p19_uart_tx` on the peripheral bus side of tinyQV. It synchronises the asynchronous `uart_rxd` pin and validates the start bit at mid-bit. It then samples PAYLOAD_BITS data bits LSB-first and checks the stop bit. Each received byte is presented in a one-entry holding register with a valid/read handshake, plus sticky overrun and framing-error flags.

---
 rtl/p19_uart_rx.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/p19_uart_rx.sv
// UART receiver: two-flop input synchroniser, mid-bit start validation, LSB-first
// data capture, one-entry holding register with sticky overrun/framing flags.
//
// state  | meaning
// IDLE   | line idle, waiting for rxd_s low
// START  | timing to mid start bit; reject glitches
// DATA   | sampling PAYLOAD_BITS data bits, one per bit period
// STOP   | sampling the first stop bit
// BREAK  | stop bit was low; wait for line to return high
module p19_uart_rx #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_read,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_overrun,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_busy
);

  localparam int CYCLES_PER_BIT = (CLK_HZ - 1) / BIT_RATE;
  localparam int HALF           = CYCLES_PER_BIT / 2;
  localparam int CW             = 1 + $clog2(CYCLES_PER_BIT);
  localparam int IW             = $clog2(PAYLOAD_BITS + 1);

  localparam logic [CW-1:0] CNT_FULL = CW'(CYCLES_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [IW-1:0] IDX_LAST = IW'(PAYLOAD_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  // Only the first stop bit is checked, so any count of one or more is accepted.
  if (STOP_BITS < 1) begin : g_stop_bits_check
    $error("p19_uart_rx: STOP_BITS must be at least 1");
  end

  logic                    meta_q;
  logic                    rxd_s_q;
  logic [2:0]              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic                    valid_q, valid_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    ovr_q, ovr_d;
  logic                    ferr_q, ferr_d;
  logic                    busy_q, busy_d;
  logic                    done;
  logic                    ferr_hit;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    done     = 1'b0;
    ferr_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxd_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rxd_s_q) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_FULL) begin
          // Line order is LSB first, so each new bit enters at the MSB.
          shift_d = PAYLOAD_BITS'({rxd_s_q, shift_q} >> 1);
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rxd_s_q) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_hit = 1'b1;
            state_d  = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (rxd_s_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Holding register: a completing byte or a new flag always wins over a read.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    ferr_d  = ferr_q;
    if (uart_rx_read) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
      ferr_d  = 1'b0;
    end
    if (done) begin
      if (!valid_q || uart_rx_read) begin
        valid_d = 1'b1;
        data_d  = shift_q;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (ferr_hit) begin
      ferr_d = 1'b1;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_q  <= 1'b1;
      rxd_s_q <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      meta_q  <= uart_rxd;
      rxd_s_q <= meta_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign uart_rx_valid     = valid_q;
  assign uart_rx_data      = data_q;
  assign uart_rx_overrun   = ovr_q;
  assign uart_rx_frame_err = ferr_q;
  assign uart_rx_busy      = busy_q;

endmodule
